// File: rtl/trace_capture_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : trace_capture_buffer_if
//  Purpose  : Groups the commit-bus tap and the valid/ready readout port of
//             trace_capture_buffer into one bundle.
//  Signals  : pc, inst, alu_result, wd, rd (XLEN each), regwrite, memwrite
//               - commit-bus sample driven by the core side (master)
//             rd_valid, rd_data (ENTRY_W) - readout driven by the buffer
//             rd_ready                    - readout accept from the consumer
//  Modports : master - core/consumer side; slave - capture buffer side
//  Revision : 1.0 - initial release
// ============================================================================
interface trace_capture_buffer_if #(
    parameter int XLEN    = 32,
    parameter int ENTRY_W = 5 * XLEN + 2
);
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    inst;
    logic [XLEN-1:0]    alu_result;
    logic [XLEN-1:0]    wd;
    logic [XLEN-1:0]    rd;
    logic               regwrite;
    logic               memwrite;
    logic               rd_valid;
    logic               rd_ready;
    logic [ENTRY_W-1:0] rd_data;

    modport master (
        output pc, inst, alu_result, wd, rd, regwrite, memwrite, rd_ready,
        input  rd_valid, rd_data
    );

    modport slave (
        input  pc, inst, alu_result, wd, rd, regwrite, memwrite, rd_ready,
        output rd_valid, rd_data
    );
endinterface
`default_nettype wire

// File: rtl/trace_capture_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : trace_capture_buffer
//  Purpose  : On-chip trace capture for the risc_v core. Samples the per-cycle
//             commit bus into a DEPTH-entry ring with pre/post-trigger
//             windowing, then replays the window over a valid/ready port.
//  Ports    : clk, reset (sync, active-high)
//             arm      - start capture (honoured only when idle)
//             trig_en  - 1: trigger on pc==trig_pc, 0: trigger on first sample
//             trig_pc  - trigger PC
//             busy     - capture in progress (PRE or POST)
//             done     - window ready for readout
//             entries  - captured entry count, valid while done
//             bus      - commit-bus tap and readout (trace_capture_buffer_if)
//  Options  : TRACE_TIMESTAMP_EN - adds a free-running TS_W-bit cycle stamp in
//             the MSBs of every entry.
//  Revision : 1.0 - initial release
// ============================================================================
module trace_capture_buffer #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 64,
    parameter int PRE_TRIG = 16,
    parameter int TS_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    arm,
    input  logic                    trig_en,
    input  logic [XLEN-1:0]         trig_pc,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(DEPTH):0]  entries,
    trace_capture_buffer_if.slave   bus
);

    localparam int c_AW       = $clog2(DEPTH);
    localparam int c_CW       = c_AW + 1;
    localparam int c_POST     = DEPTH - PRE_TRIG - 1;
    localparam int c_BASE_W   = 5 * XLEN + 2;
`ifdef TRACE_TIMESTAMP_EN
    localparam int c_ENTRY_W  = c_BASE_W + TS_W;
`else
    localparam int c_ENTRY_W  = c_BASE_W;
`endif
    localparam int c_CAP_BASE = DEPTH - PRE_TRIG;   // trigger entry + POST

    localparam logic [c_AW-1:0] c_PRE_MAX  = PRE_TRIG[c_AW-1:0];
    localparam logic [c_AW-1:0] c_POST_A   = c_POST[c_AW-1:0];
    localparam logic [c_CW-1:0] c_CAP_ADD  = c_CAP_BASE[c_CW-1:0];
    localparam bit              c_NO_POST  = (c_POST == 0);

    // Elaboration-time parameter legality checks
    generate
        if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("trace_capture_buffer: DEPTH must be a power of 2 and >= 4");
        end
        if ((PRE_TRIG < 0) || (PRE_TRIG >= DEPTH)) begin : g_bad_pre
            $error("trace_capture_buffer: PRE_TRIG must satisfy 0 <= PRE_TRIG < DEPTH");
        end
        if (TS_W < 1) begin : g_bad_ts
            $error("trace_capture_buffer: TS_W must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_POST = 2'd2,
        S_READ = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_AW-1:0]    r_pre_cnt;
    logic [c_AW-1:0]    r_post_cnt;
    logic [c_CW-1:0]    r_cap_cnt;
    logic [c_CW-1:0]    r_entries;
    logic [c_CW-1:0]    r_remaining;

    logic [c_ENTRY_W-1:0] r_ring [DEPTH];

    logic               w_trigger;
    logic               w_write;
    logic               w_fire;
    logic               w_last_post;
    logic               w_last_read;
    logic [c_CW-1:0]    w_cap_cnt;
    logic [c_ENTRY_W-1:0] w_entry;

    // ------------------------------------------------------------------------
    // Entry formation
    // ------------------------------------------------------------------------
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]    r_ts;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    assign w_entry = {r_ts, bus.regwrite, bus.memwrite, bus.pc, bus.inst,
                      bus.alu_result, bus.wd, bus.rd};
`else
    assign w_entry = {bus.regwrite, bus.memwrite, bus.pc, bus.inst,
                      bus.alu_result, bus.wd, bus.rd};
`endif

    // ------------------------------------------------------------------------
    // Combinational control terms
    // ------------------------------------------------------------------------
    assign w_trigger   = !trig_en || (bus.pc == trig_pc);
    assign w_write     = (r_state == S_PRE) || (r_state == S_POST);
    assign w_fire      = (r_state == S_READ) && bus.rd_ready;
    assign w_last_post = (r_post_cnt == {{(c_AW-1){1'b0}}, 1'b1});
    assign w_last_read = w_fire && (r_remaining == {{(c_CW-1){1'b0}}, 1'b1});
    // pre_cnt is the count before this cycle's increment, i.e. the number of
    // pre-trigger entries still resident in the ring.
    assign w_cap_cnt   = {1'b0, r_pre_cnt} + c_CAP_ADD;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        bus.rd_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (arm) begin
                    w_state_nxt = S_PRE;
                end
            end
            S_PRE: begin
                busy = 1'b1;
                if (w_trigger) begin
                    w_state_nxt = c_NO_POST ? S_READ : S_POST;
                end
            end
            S_POST: begin
                busy = 1'b1;
                if (w_last_post) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                done         = 1'b1;
                bus.rd_valid = 1'b1;
                if (w_last_read) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Pointers and counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_pre_cnt   <= '0;
            r_post_cnt  <= '0;
            r_cap_cnt   <= '0;
            r_entries   <= '0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (arm) begin
                        r_wr_ptr  <= '0;
                        r_pre_cnt <= '0;
                    end
                end
                S_PRE: begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (r_pre_cnt != c_PRE_MAX) begin
                        r_pre_cnt <= r_pre_cnt + 1'b1;
                    end
                    if (w_trigger) begin
                        // Oldest kept pre-trigger entry; wraps naturally
                        r_rd_ptr   <= r_wr_ptr - r_pre_cnt;
                        r_post_cnt <= c_POST_A;
                        r_cap_cnt  <= w_cap_cnt;
                        if (c_NO_POST) begin
                            r_entries   <= w_cap_cnt;
                            r_remaining <= w_cap_cnt;
                        end
                    end
                end
                S_POST: begin
                    r_wr_ptr   <= r_wr_ptr + 1'b1;
                    r_post_cnt <= r_post_cnt - 1'b1;
                    if (w_last_post) begin
                        r_entries   <= r_cap_cnt;
                        r_remaining <= r_cap_cnt;
                    end
                end
                S_READ: begin
                    if (w_fire) begin
                        r_rd_ptr    <= r_rd_ptr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Ring storage (contents intentionally not cleared by reset)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset && w_write) begin
            r_ring[r_wr_ptr] <= w_entry;
        end
    end

    assign bus.rd_data = r_ring[r_rd_ptr];
    assign entries     = r_entries;

endmodule
`default_nettype wire

// File: tb/tb_trace_capture_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trace_capture_buffer
//  Purpose  : Directed self-checking bench for trace_capture_buffer with
//             DEPTH=8, PRE_TRIG=3 (POST=4). The commit-bus pc counts up by 4
//             from 0x00 starting the cycle after arm; other fields are fixed
//             functions of pc so every entry is predictable.
//  Options  : TRACE_TIMESTAMP_EN - also checks consecutive timestamps.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_trace_capture_buffer;

    localparam int c_XLEN     = 32;
    localparam int c_DEPTH    = 8;
    localparam int c_PRE_TRIG = 3;
    localparam int c_TS_W     = 16;
    localparam int c_BASE_W   = 5 * c_XLEN + 2;
`ifdef TRACE_TIMESTAMP_EN
    localparam int c_ENTRY_W  = c_BASE_W + c_TS_W;
`else
    localparam int c_ENTRY_W  = c_BASE_W;
`endif

    logic        clk;
    logic        reset;
    logic        arm;
    logic        trig_en;
    logic [31:0] trig_pc;
    logic        busy;
    logic        done;
    logic [3:0]  entries;

    int checks   = 0;
    int failures = 0;

    trace_capture_buffer_if #(.XLEN(c_XLEN), .ENTRY_W(c_ENTRY_W)) bus ();

    trace_capture_buffer #(
        .XLEN     (c_XLEN),
        .DEPTH    (c_DEPTH),
        .PRE_TRIG (c_PRE_TRIG),
        .TS_W     (c_TS_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .arm     (arm),
        .trig_en (trig_en),
        .trig_pc (trig_pc),
        .busy    (busy),
        .done    (done),
        .entries (entries),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [c_BASE_W-1:0] exp_entry(input logic [31:0] pc);
        logic [31:0] rdv;
        rdv = {27'd0, pc[6:2]};
        return {pc[2], pc[3], pc, pc ^ 32'hDEAD_BEEF, pc + 32'h100, ~pc, rdv};
    endfunction

    task automatic drive(input logic [31:0] pc);
        bus.pc         = pc;
        bus.inst       = pc ^ 32'hDEAD_BEEF;
        bus.alu_result = pc + 32'h100;
        bus.wd         = ~pc;
        bus.rd         = {27'd0, pc[6:2]};
        bus.regwrite   = pc[2];
        bus.memwrite   = pc[3];
    endtask

    // Arm, then feed pc = 0,4,8,... until done (bounded).
    task automatic run_capture(input bit te, input logic [31:0] tpc,
                               input int exp_n, input string name);
        logic [31:0] pc_v;
        int cyc;
        trig_en = te;
        trig_pc = tpc;
        arm     = 1'b1;
        tick();
        arm     = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_busy: busy=%b expected=1", name, busy);
        end
        pc_v = 32'h0;
        cyc  = 0;
        while (done !== 1'b1 && cyc < 40) begin
            drive(pc_v);
            tick();
            pc_v += 32'd4;
            cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s_done_timeout: done=%b expected=1", name, done);
        end
        checks++;
        if (entries !== exp_n[3:0]) begin
            failures++;
            $display("FAIL %s_entries: entries=%0d expected=%0d", name, entries, exp_n);
        end
    endtask

    // Read n entries expected to carry pc first_pc, first_pc+4, ...
    task automatic read_out(input int n, input logic [31:0] first_pc,
                            input bit stall, input string name);
        int idx;
        int cyc;
        logic [7:0] lfsr;
        logic rdy;
        logic [31:0] epc;
`ifdef TRACE_TIMESTAMP_EN
        logic [c_TS_W-1:0] ts_prev;
        logic [c_TS_W-1:0] ts_cur;
        int ts_idx;
        ts_prev = '0;
        ts_idx  = -1;
`endif
        idx  = 0;
        cyc  = 0;
        lfsr = 8'hA7;
        while (idx < n && cyc < 200) begin
            rdy  = stall ? lfsr[0] : 1'b1;
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            bus.rd_ready = rdy;
            epc = first_pc + 32'(4 * idx);
            checks++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data[c_BASE_W-1:0] !== exp_entry(epc)) begin
                failures++;
                $display("FAIL %s_entry%0d: rd_valid=%b pc=%h expected rd_valid=1 pc=%h",
                         name, idx, bus.rd_valid, bus.rd_data[c_BASE_W-3 -: 32], epc);
            end
`ifdef TRACE_TIMESTAMP_EN
            ts_cur = bus.rd_data[c_ENTRY_W-1 -: c_TS_W];
            if (idx != ts_idx) begin
                if (idx > 0) begin
                    checks++;
                    if (ts_cur !== ts_prev + 1'b1) begin
                        failures++;
                        $display("FAIL %s_ts%0d: ts=%0d expected=%0d",
                                 name, idx, ts_cur, ts_prev + 1'b1);
                    end
                end
                ts_prev = ts_cur;
                ts_idx  = idx;
            end
`endif
            tick();
            if (rdy) idx++;
            cyc++;
        end
        bus.rd_ready = 1'b0;
        checks++;
        if (idx != n) begin
            failures++;
            $display("FAIL %s_read_timeout: read=%0d expected=%0d", name, idx, n);
        end
        checks++;
        if (bus.rd_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_after_read: rd_valid=%b done=%b busy=%b expected 0/0/0",
                     name, bus.rd_valid, done, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bus.rd_valid !== 1'b0 || entries !== 4'd0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b rd_valid=%b entries=%0d expected 0/0/0/0",
                     busy, done, bus.rd_valid, entries);
        end
        reset = 1'b0;
        tick();
    endtask

    // Immediate trigger, plus arm pulses during READ that must be ignored
    task automatic test_free_trigger();
        run_capture(1'b0, 32'h0, 5, "free");
        arm = 1'b1;
        tick();
        arm = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || entries !== 4'd5) begin
            failures++;
            $display("FAIL arm_in_read: done=%b busy=%b entries=%0d expected 1/0/5",
                     done, busy, entries);
        end
        read_out(5, 32'h00, 1'b0, "free");
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL arm_in_read_latched: busy=%b expected=0", busy);
        end
    endtask

    task automatic test_pc_trigger();
        run_capture(1'b1, 32'h20, 8, "pctrig");
        read_out(8, 32'h14, 1'b0, "pctrig");
        tick();
    endtask

    task automatic test_early_trigger();
        run_capture(1'b1, 32'h04, 6, "early");
        read_out(6, 32'h00, 1'b0, "early");
        tick();
    endtask

    task automatic test_reset_in_post();
        trig_en = 1'b0;
        arm     = 1'b1;
        tick();
        arm     = 1'b0;
        drive(32'h0);
        tick();
        drive(32'h4);
        tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL post_busy: busy=%b expected=1", busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bus.rd_valid !== 1'b0 || entries !== 4'd0) begin
            failures++;
            $display("FAIL reset_in_post: busy=%b done=%b rd_valid=%b entries=%0d expected 0/0/0/0",
                     busy, done, bus.rd_valid, entries);
        end
        tick();
    endtask

    // Re-arm after the mid-capture reset, then read with a stalling consumer
    task automatic test_stall_readout();
        run_capture(1'b1, 32'h20, 8, "stall");
        read_out(8, 32'h14, 1'b1, "stall");
        tick();
    endtask

    initial begin
        reset        = 1'b1;
        arm          = 1'b0;
        trig_en      = 1'b0;
        trig_pc      = 32'h0;
        bus.rd_ready = 1'b0;
        drive(32'h0);
        test_reset();
        test_free_trigger();
        test_pc_trigger();
        test_early_trigger();
        test_reset_in_post();
        test_stall_readout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
